alu_ctrl_stage: RTL
===================

// Module: alu_ctrl_stage
// PURPOSE
//  Registered ALU-control stage for the pipelined RV32I/RV32IM core: decodes ALUOp/funct3/funct7
//  into an ALU control code plus side flags, holds it in a one-entry valid/ready pipeline register,
//  and sequences multi-cycle M-extension ops (MUL*/DIV*/REM*) with a latency counter.
//  Sits between the main decoder (ID) and the ALU / iterative mul-div unit (EX).
//  Replaces all 4'bxxxx outcomes with a deterministic illegal flag.
// PARAMETERS
//  XLEN     32  datapath width, 32 or 64; 64 checks only funct7[6:1] for immediate shifts
//  EN_M     1   1 = decode funct7=7'h01 R-type as M-extension; 0 = flag it illegal
//  MUL_LAT  3   cycles from md_start to out_valid for MUL/MULH/MULHSU/MULHU, >=1
//  DIV_LAT  33  cycles from md_start to out_valid for DIV/DIVU/REM/REMU, >=1
//  CTRL_W   5   width of alu_ctrl
// PORTS
//  clk           in   1       clock; single clock domain
//  rst           in   1       asynchronous, active-high reset
//  flush         in   1       synchronous pipeline flush
//  in_valid      in   1       decode bundle valid
//  in_ready      out  1       stage can accept the bundle this cycle
//  alu_op        in   4       ALUOp class from main decoder
//  funct3        in   3       instr[14:12]
//  funct7        in   7       instr[31:25]
//  out_valid     out  1       alu_ctrl/flags valid to EX
//  out_ready     in   1       EX accepts
//  alu_ctrl      out  CTRL_W  ALU / mul-div operation code (`ALU_* from defines.vh)
//  illegal       out  1       encoding not recognised
//  unsigned_cmp  out  1       op is SLTU-class
//  use_md        out  1       op goes to the mul-div unit
//  md_start      out  1       one-cycle pulse: launch mul-div unit
//  md_abort      out  1       one-cycle pulse: kill in-flight mul-div op
//  md_busy       out  1       state == WAIT_MD
// BEHAVIOUR
//  Reset: state IDLE; out_valid, illegal, unsigned_cmp, use_md, md_start, md_abort = 0; alu_ctrl = `ALU_ADD.
//  Decode (combinational, registered on accept):
//   0000 load, 0010 AUIPC, 0111 JALR, 1000 JAL -> ADD
//   0011 store: funct3 0..2 -> ADD, else illegal
//   0001 imm: f3 0 ADD, 2 SLT, 3 SLTU, 4 XOR, 6 OR, 7 AND;
//     f3 1: SLL iff funct7 == 0; f3 5: SRL for 7'h00, SRA for 7'h20; else illegal
//   0100 R: funct7 00 -> ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND by f3; 20 -> SUB (f3 0) / SRA (f3 5);
//     01 with EN_M -> MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU by f3 (use_md = 1); else illegal
//   0101 LUI -> PASS_B
//   0110 branch: f3 0,1 SUB; 4,5 SLT; 6,7 SLTU; 2,3 illegal
//   other ALUOp -> illegal
//   Illegal: alu_ctrl = `ALU_ADD, illegal = 1, use_md = 0, unsigned_cmp = 0; treated as single-cycle.
//  Handshake: accept = in_valid & in_ready.
//   in_ready = !flush & (state == IDLE | (state == HOLD & out_ready)).
//   Outputs are registered; they change only on accept, reset or flush.
//  FSM:
//   IDLE --accept non-md--> HOLD; IDLE --accept md--> WAIT_MD (md_start = 1 next cycle, cnt = LAT-1)
//   WAIT_MD: cnt decrements each cycle; at cnt == 0 -> HOLD. out_valid rises exactly LAT cycles
//     after the md_start cycle.
//   HOLD: out_valid = 1. out_ready & accept -> reload (same rules, zero bubble);
//     out_ready & !accept -> IDLE; otherwise hold all outputs stable.
//  flush: highest priority; next state IDLE, out_valid = 0, no accept that cycle;
//   if in WAIT_MD, md_abort pulses 1 cycle; no md_start after a flush.
//  Counter width: clog2(max(MUL_LAT, DIV_LAT)) + 1; never wraps.
// STRUCTURE
//  defines.vh: `ALU_* codes, widened to CTRL_W (existing ADD/SUB/XOR/OR/AND/shift codes unchanged;
//   add SLT, SLTU, PASS_B, MUL..REMU) and ALUOp class constants.
//  Sub-module alu_ctrl_decode: pure combinational decoder (code + flags).
//  This module holds the FSM, counter and output register.
// TESTING
//  1. R-type: ALUOp 0100, f3 0, f7 20, out_ready = 1 -> next cycle out_valid = 1, alu_ctrl = `ALU_SUB, illegal = 0.
//  2. Back-to-back: ADD then SRAI (0001, f3 5, f7 20) with out_ready = 1 -> no bubble; in_ready stays 1;
//     outputs ADD then SRA on consecutive cycles.
//  3. DIVU (0100, f3 5, f7 01): md_start pulse; md_busy for 33 cycles; out_valid rises on cycle 33
//     after md_start; in_ready = 0 throughout.
//  4. Illegal: store f3 3, branch f3 2, ALUOp 1111, and EN_M = 0 with MUL -> illegal = 1, alu_ctrl = `ALU_ADD, no md_start.
//  5. Backpressure: out_ready = 0 for 5 cycles in HOLD -> outputs stable, in_ready = 0;
//     out_ready = 1 -> accept resumes.
//  6. flush at cycle 10 of DIV -> md_abort pulse, out_valid never rises; async rst mid-WAIT_MD
//     -> all outputs at reset values immediately.

Source files
------------

// File: rtl/alu_ctrl_stage_pkg.sv
// rtl/alu_ctrl_stage_pkg.sv - ALU control codes, ALUOp classes and decode result type
package alu_ctrl_stage_pkg;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_SLL    = 5'd2;
    localparam logic [4:0] ALU_SLT    = 5'd3;
    localparam logic [4:0] ALU_SLTU   = 5'd4;
    localparam logic [4:0] ALU_XOR    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_OR     = 5'd8;
    localparam logic [4:0] ALU_AND    = 5'd9;
    localparam logic [4:0] ALU_PASS_B = 5'd10;
    // M-extension codes occupy 16..23 so bit 4 marks mul-div and bit 2 marks the divide group
    localparam logic [4:0] ALU_MUL    = 5'd16;
    localparam logic [4:0] ALU_MULH   = 5'd17;
    localparam logic [4:0] ALU_MULHSU = 5'd18;
    localparam logic [4:0] ALU_MULHU  = 5'd19;
    localparam logic [4:0] ALU_DIV    = 5'd20;
    localparam logic [4:0] ALU_DIVU   = 5'd21;
    localparam logic [4:0] ALU_REM    = 5'd22;
    localparam logic [4:0] ALU_REMU   = 5'd23;

    localparam logic [3:0] OP_LOAD   = 4'b0000;
    localparam logic [3:0] OP_IMM    = 4'b0001;
    localparam logic [3:0] OP_AUIPC  = 4'b0010;
    localparam logic [3:0] OP_STORE  = 4'b0011;
    localparam logic [3:0] OP_R      = 4'b0100;
    localparam logic [3:0] OP_LUI    = 4'b0101;
    localparam logic [3:0] OP_BRANCH = 4'b0110;
    localparam logic [3:0] OP_JALR   = 4'b0111;
    localparam logic [3:0] OP_JAL    = 4'b1000;

    typedef struct packed {
        logic [4:0] code;
        logic       illegal;
        logic       unsigned_cmp;
        logic       use_md;
        logic       is_div;
    } dec_t;

    localparam dec_t DEC_ILLEGAL = '{code: ALU_ADD, illegal: 1'b1, unsigned_cmp: 1'b0,
                                     use_md: 1'b0, is_div: 1'b0};

    function automatic dec_t dec_ok(input logic [4:0] c);
        dec_t d;
        d.code         = c;
        d.illegal      = 1'b0;
        d.unsigned_cmp = (c == ALU_SLTU);
        d.use_md       = c[4];
        d.is_div       = c[4] & c[2];
        return d;
    endfunction

    function automatic logic [4:0] base_op(input logic [2:0] f3);
        logic [4:0] c;
        case (f3)
            3'd0:    c = ALU_ADD;
            3'd1:    c = ALU_SLL;
            3'd2:    c = ALU_SLT;
            3'd3:    c = ALU_SLTU;
            3'd4:    c = ALU_XOR;
            3'd5:    c = ALU_SRL;
            3'd6:    c = ALU_OR;
            default: c = ALU_AND;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - combinational ALUOp/funct3/funct7 to ALU control code decoder
module alu_ctrl_decode
    import alu_ctrl_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int EN_M = 1
) (
    input  logic [3:0] alu_op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [4:0] code,
    output logic       illegal,
    output logic       unsigned_cmp,
    output logic       use_md,
    output logic       is_div
);

    localparam bit RV64 = (XLEN == 64);

    // RV64 immediate shifts carry shamt[5] in funct7[0], so only the upper six bits select the op
    logic imm_sll_ok;
    logic imm_sra_ok;
    assign imm_sll_ok = RV64 ? (funct7[6:1] == 6'h00) : (funct7 == 7'h00);
    assign imm_sra_ok = RV64 ? (funct7[6:1] == 6'h10) : (funct7 == 7'h20);

    dec_t d;

    always_comb begin
        d = DEC_ILLEGAL;
        case (alu_op)
            OP_LOAD, OP_AUIPC, OP_JALR, OP_JAL: d = dec_ok(ALU_ADD);
            OP_STORE: if (funct3 <= 3'd2) d = dec_ok(ALU_ADD);
            OP_IMM: begin
                if (funct3 == 3'd1) begin
                    if (imm_sll_ok) d = dec_ok(ALU_SLL);
                end else if (funct3 == 3'd5) begin
                    if (imm_sll_ok)      d = dec_ok(ALU_SRL);
                    else if (imm_sra_ok) d = dec_ok(ALU_SRA);
                end else begin
                    d = dec_ok(base_op(funct3));
                end
            end
            OP_R: begin
                if (funct7 == 7'h00) begin
                    d = dec_ok(base_op(funct3));
                end else if (funct7 == 7'h20) begin
                    if (funct3 == 3'd0)      d = dec_ok(ALU_SUB);
                    else if (funct3 == 3'd5) d = dec_ok(ALU_SRA);
                end else if (funct7 == 7'h01 && EN_M != 0) begin
                    d = dec_ok(ALU_MUL | {2'b00, funct3});
                end
            end
            OP_LUI: d = dec_ok(ALU_PASS_B);
            OP_BRANCH: begin
                case (funct3)
                    3'd0, 3'd1: d = dec_ok(ALU_SUB);
                    3'd4, 3'd5: d = dec_ok(ALU_SLT);
                    3'd6, 3'd7: d = dec_ok(ALU_SLTU);
                    default:    d = DEC_ILLEGAL;
                endcase
            end
            default: d = DEC_ILLEGAL;
        endcase
    end

    assign code         = d.code;
    assign illegal      = d.illegal;
    assign unsigned_cmp = d.unsigned_cmp;
    assign use_md       = d.use_md;
    assign is_div       = d.is_div;

endmodule

// File: rtl/alu_ctrl_stage.sv
// rtl/alu_ctrl_stage.sv - registered ALU control stage with valid/ready handshake and mul-div sequencing
module alu_ctrl_stage
    import alu_ctrl_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int EN_M    = 1,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 33,
    parameter int CTRL_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        alu_op,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              illegal,
    output logic              unsigned_cmp,
    output logic              use_md,
    output logic              md_start,
    output logic              md_abort,
    output logic              md_busy
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT_MD = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    logic [4:0] d_code;
    logic       d_illegal;
    logic       d_unsigned_cmp;
    logic       d_use_md;
    logic       d_is_div;

    alu_ctrl_decode #(
        .XLEN (XLEN),
        .EN_M (EN_M)
    ) u_decode (
        .alu_op       (alu_op),
        .funct3       (funct3),
        .funct7       (funct7),
        .code         (d_code),
        .illegal      (d_illegal),
        .unsigned_cmp (d_unsigned_cmp),
        .use_md       (d_use_md),
        .is_div       (d_is_div)
    );

    assign in_ready = !flush && (state == S_IDLE || (state == S_HOLD && out_ready));
    assign accept   = in_valid && in_ready;
    assign md_busy  = (state == S_WAIT_MD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            out_valid    <= 1'b0;
            alu_ctrl     <= CTRL_W'(ALU_ADD);
            illegal      <= 1'b0;
            unsigned_cmp <= 1'b0;
            use_md       <= 1'b0;
            md_start     <= 1'b0;
            md_abort     <= 1'b0;
        end else begin
            md_start <= 1'b0;
            md_abort <= 1'b0;
            if (flush) begin
                state     <= S_IDLE;
                cnt       <= '0;
                out_valid <= 1'b0;
                md_abort  <= (state == S_WAIT_MD);
            end else if (accept) begin
                alu_ctrl     <= CTRL_W'(d_code);
                illegal      <= d_illegal;
                unsigned_cmp <= d_unsigned_cmp;
                use_md       <= d_use_md;
                if (d_use_md) begin
                    state     <= S_WAIT_MD;
                    out_valid <= 1'b0;
                    md_start  <= 1'b1;
                    cnt       <= d_is_div ? DIV_LOAD : MUL_LOAD;
                end else begin
                    state     <= S_HOLD;
                    out_valid <= 1'b1;
                end
            end else if (state == S_WAIT_MD) begin
                // cnt was loaded with LAT-1, so HOLD is reached LAT cycles after md_start
                if (cnt == '0) begin
                    state     <= S_HOLD;
                    out_valid <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end else if (state == S_HOLD && out_ready) begin
                state     <= S_IDLE;
                out_valid <= 1'b0;
            end
        end
    end

endmodule
